// File: rtl/median_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : median_stream_ctrl
// Brief    : Collects an N-sample window, drives an external sort network and
//            returns median/min/max on a valid/ready stream (block or sliding).
// Revision : 1.0 - initial release
// ============================================================================
module median_stream_ctrl #(
    parameter int W = 32,
    parameter int N = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   cfg_sliding,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    output logic [N*W-1:0]         net_data,
    input  logic [N*W-1:0]         net_sort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_median,
    output logic [W-1:0]           out_min,
    output logic [W-1:0]           out_max,
    output logic [$clog2(N+1)-1:0] fill_count
);

    localparam int                 c_CNT_W   = $clog2(N+1);
    localparam int                 c_MID     = (N-1)/2;
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(N-1);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CAPT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_fill;
    logic [c_CNT_W-1:0]   w_fill_nxt;
    logic                 r_active;
    logic [W-1:0]         r_win [N];
    logic [W-1:0]         r_median;
    logic [W-1:0]         r_min;
    logic [W-1:0]         r_max;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_unused_sort;

    // Only three network slots are consumed; the rest are intentionally ignored.
    assign w_unused_sort = ^net_sort;

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                in_ready = r_active & ~flush;
                w_accept = in_valid & r_active & ~flush;
                if (w_accept) begin
                    w_fill_nxt = r_fill + c_ONE;
                    if (r_fill == c_FULL_M1) begin
                        w_state_nxt = ST_CAPT;
                    end
                end
            end
            ST_CAPT: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_FILL;
                    // Sliding keeps N-1 samples so the next accept completes a window.
                    w_fill_nxt  = cfg_sliding ? c_FULL_M1 : '0;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_FILL;
            w_fill_nxt  = '0;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_FILL;
            r_fill   <= '0;
            r_active <= 1'b0;
            r_median <= '0;
            r_min    <= '0;
            r_max    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fill   <= w_fill_nxt;
            r_active <= 1'b1;
            if (w_capture) begin
                r_median <= net_sort[c_MID*W +: W];
                r_min    <= net_sort[0 +: W];
                r_max    <= net_sort[(N-1)*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            r_win[0] <= in_data;
            for (int k = 1; k < N; k++) begin
                r_win[k] <= r_win[k-1];
            end
        end
    end

    generate
        for (genvar k = 0; k < N; k++) begin : g_pack
            assign net_data[k*W +: W] = r_win[k];
        end
    endgenerate

    assign out_median = r_median;
    assign out_min    = r_min;
    assign out_max    = r_max;
    assign fill_count = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_median_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_median_stream_ctrl
// Brief    : Scoreboard bench for median_stream_ctrl with a behavioural sorter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_median_stream_ctrl;

    localparam int W  = 32;
    localparam int N  = 11;
    localparam int CW = $clog2(N+1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            flush = 1'b0;
    logic            cfg_sliding = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [W-1:0]    in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [N*W-1:0]  net_data;
    logic [N*W-1:0]  net_sort;
    logic [W-1:0]    out_median;
    logic [W-1:0]    out_min;
    logic [W-1:0]    out_max;
    logic [CW-1:0]   fill_count;

    typedef struct packed {
        logic [W-1:0] med;
        logic [W-1:0] mn;
        logic [W-1:0] mx;
    } res_t;

    res_t         exp_q[$];
    logic [W-1:0] hist[$];
    int           model_cnt = 0;
    int           vectors = 0;
    int           miscompares = 0;
    int           rdy_mode = 0;

    median_stream_ctrl #(.W(W), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .cfg_sliding(cfg_sliding),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .net_data   (net_data),
        .net_sort   (net_sort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_median (out_median),
        .out_min    (out_min),
        .out_max    (out_max),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    // External combinational network: plain bubble sort, ascending.
    function automatic logic [N*W-1:0] sort_net(input logic [N*W-1:0] v);
        logic [W-1:0] a [N];
        logic [W-1:0] t;
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) a[i] = v[i*W +: W];
        for (int i = 0; i < N-1; i++)
            for (int j = 0; j < N-1-i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i];
        return r;
    endfunction

    assign net_sort = sort_net(net_data);

    // Reference: a result is the sorted last N accepted samples.
    function automatic void model_accept(input logic [W-1:0] d);
        logic [W-1:0] w[$];
        res_t r;
        hist.push_back(d);
        model_cnt++;
        if (model_cnt == N) begin
            for (int i = 0; i < N; i++) w.push_back(hist[hist.size()-N+i]);
            w.sort();
            r.med = w[(N-1)/2];
            r.mn  = w[0];
            r.mx  = w[N-1];
            exp_q.push_back(r);
            model_cnt = cfg_sliding ? N-1 : 0;
        end
    endfunction

    function automatic logic [N*W-1:0] model_window();
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = hist[hist.size()-1-k];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event within bound, want one", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            timeout("send_stall");
            in_valid = 1'b0;
            tick();
            return;
        end
        model_accept(d);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        if (!out_valid) timeout(name);
    endtask

    task automatic drain();
        int g;
        g = 0;
        rdy_mode = 0;
        while (exp_q.size() != 0 && g < 500) begin
            tick();
            g++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input logic sliding);
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        cfg_sliding = sliding;
        exp_q.delete();
        hist.delete();
        model_cnt = 0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_fill_count", 64'(fill_count), 64'd0);
        check("rst_median", 64'(out_median), 64'd0);
        check("rst_min", 64'(out_min), 64'd0);
        check("rst_max", 64'(out_max), 64'd0);
        check("rst_window_nonzero", 64'(|net_data), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        tick();
        check("rel_in_ready_high", 64'(in_ready), 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin : mon
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_result: got med %0d min %0d max %0d, want no result",
                         out_median, out_min, out_max);
            end else begin
                e = exp_q.pop_front();
                if ({out_median, out_min, out_max} !== {e.med, e.mn, e.mx}) begin
                    miscompares++;
                    $display("FAIL result: got med %0d min %0d max %0d, want med %0d min %0d max %0d",
                             out_median, out_min, out_max, e.med, e.mn, e.mx);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        #3;
        do_reset(1'b0);

        // Block mode, descending 11..1
        rdy_mode = 0;
        for (int i = 11; i >= 1; i--) send(W'(i));
        check("blk_capt_valid", 64'(out_valid), 64'd0);
        check("blk_capt_count", 64'(fill_count), 64'd11);
        check("blk_capt_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("blk_valid_rise", 64'(out_valid), 64'd1);
        check("blk_median", 64'(out_median), 64'd6);
        check("blk_min", 64'(out_min), 64'd1);
        check("blk_max", 64'(out_max), 64'd11);
        tick();
        check("blk_count_zero", 64'(fill_count), 64'd0);
        check("blk_valid_fall", 64'(out_valid), 64'd0);
        drain();

        // Sliding mode: 1..11, 100, 0
        do_reset(1'b1);
        rdy_mode = 0;
        for (int i = 1; i <= 11; i++) send(W'(i));
        check("sl_capt_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("sl_out_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("sl_count_keep", 64'(fill_count), 64'd10);
        check("sl_fill_in_ready", 64'(in_ready), 64'd1);
        send(W'(100));
        send(W'(0));
        drain();

        // Backpressure with a junk sample offered while the result is held
        do_reset(1'b0);
        rdy_mode = 2;
        for (int i = 0; i < N; i++) send($urandom);
        wait_valid("bp_wait_valid");
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_median", 64'(out_median), 64'(exp_q[0].med));
            vectors++;
            if (net_data !== model_window()) begin
                miscompares++;
                $display("FAIL bp_window: got %h, want %h", net_data, model_window());
            end
            tick();
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        tick();
        rdy_mode = 2;
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_popped_once", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        check("bp_no_repeat", 64'(out_valid), 64'd0);

        // Flush after 5 samples, with a sample offered in the flush cycle
        do_reset(1'b0);
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) send($urandom);
        in_valid = 1'b1;
        in_data  = W'(99);
        flush    = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        model_cnt = 0;
        check("fl_count", 64'(fill_count), 64'd0);
        check("fl_no_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < N; i++) send(W'(7));
        wait_valid("fl_wait_valid");
        check("fl_median", 64'(out_median), 64'd7);
        check("fl_min", 64'(out_min), 64'd7);
        check("fl_max", 64'(out_max), 64'd7);
        drain();

        // Reset while a result is pending in OUT
        do_reset(1'b0);
        rdy_mode = 2;
        for (int i = 0; i < N; i++) send($urandom);
        wait_valid("ro_wait_valid");
        do_reset(1'b0);
        rdy_mode = 0;
        for (int i = 0; i < N-1; i++) send($urandom);
        repeat (4) tick();
        check("ro_no_result", 64'(out_valid), 64'd0);
        check("ro_count", 64'(fill_count), 64'd10);
        send($urandom);
        drain();

        // Random streams in both modes with random out_ready
        for (int m = 0; m < 2; m++) begin
            do_reset(1'(m));
            rdy_mode = 1;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                if ($urandom_range(0, 1) == 1) d = $urandom;
                else d = $urandom_range(0, 15);
                send(d);
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
